// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU subsystem: function codes, command bytes, sequencer states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sys_pkg;

  // ALU function codes, shared with the ALU itself; 4'hF is unused
  localparam logic [3:0] FUN_ADD   = 4'h0;
  localparam logic [3:0] FUN_SUB   = 4'h1;
  localparam logic [3:0] FUN_MUL   = 4'h2;
  localparam logic [3:0] FUN_DIV   = 4'h3;
  localparam logic [3:0] FUN_AND   = 4'h4;
  localparam logic [3:0] FUN_OR    = 4'h5;
  localparam logic [3:0] FUN_NAND  = 4'h6;
  localparam logic [3:0] FUN_NOR   = 4'h7;
  localparam logic [3:0] FUN_XOR   = 4'h8;
  localparam logic [3:0] FUN_XNOR  = 4'h9;
  localparam logic [3:0] FUN_CMPEQ = 4'hA;
  localparam logic [3:0] FUN_CMPG  = 4'hB;
  localparam logic [3:0] FUN_CMPL  = 4'hC;
  localparam logic [3:0] FUN_SLL   = 4'hD;
  localparam logic [3:0] FUN_SLR   = 4'hE;

  // Command framing bytes on the UART stream
  localparam logic [7:0] DEF_CMD_OPS   = 8'hCC;  // CC, A, B, FUN
  localparam logic [7:0] DEF_CMD_NOOPS = 8'hDD;  // DD, FUN (reuse stored operands)
  localparam logic [7:0] DEF_ERR_BYTE  = 8'hEE;  // returned when the ALU never answers

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_WR_A,
    ST_WR_B,
    ST_ALU_RUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI,
    ST_TX_ERR
  } state_e;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Parses UART command frames, loads operands into the register file, runs the ALU, returns the result.
// Latency: outputs registered; 1 cycle per rf write, ALU_WAIT up to TIMEOUT cycles, then 2 TX bytes.
// Backpressure: TX bytes held with valid high until i_tx_ready; RX bytes outside parsing states are dropped.
module alu_cmd_ctrl
  import alu_sys_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                FUN       = 4,
  parameter int                BUSR      = 16,   // must be 2*DATA_W
  parameter int                ADDR_W    = 4,
  parameter int                OPA_ADDR  = 0,
  parameter int                OPB_ADDR  = 1,
  parameter logic [DATA_W-1:0] CMD_OPS   = DEF_CMD_OPS,
  parameter logic [DATA_W-1:0] CMD_NOOPS = DEF_CMD_NOOPS,
  parameter logic [DATA_W-1:0] ERR_BYTE  = DEF_ERR_BYTE,
  parameter int                TIMEOUT   = 8
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rf_wr_en,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic              o_alu_en,
  output logic [FUN-1:0]    o_alu_fun,
  input  logic [BUSR-1:0]   i_alu_res,
  input  logic              i_alu_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_rx_drop
);

  // Wide enough to hold TIMEOUT-1 even when TIMEOUT is a power of two or 1
  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // Sequencer state and frame context
  state_e            state_q,    state_d;
  logic [DATA_W-1:0] a_q,        a_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic [FUN-1:0]    fun_q,      fun_d;
  logic              ops_flag_q, ops_flag_d;   // frame carried operands -> write them first
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BUSR-1:0]   res_q,      res_d;

  // Registered outputs
  logic              rf_wr_en_q,  rf_wr_en_d;
  logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
  logic              alu_en_q,    alu_en_d;
  logic [FUN-1:0]    alu_fun_q,   alu_fun_d;
  logic [DATA_W-1:0] tx_data_q,   tx_data_d;
  logic              tx_valid_q,  tx_valid_d;
  logic              busy_q,      busy_d;
  logic              rx_drop_q,   rx_drop_d;

  // Next-state, frame capture and timeout counting
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    ops_flag_d = ops_flag_q;
    cnt_d      = cnt_q;
    res_d      = res_q;

    case (state_q)
      ST_IDLE: begin
        // Anything other than a header byte is line noise and is ignored quietly
        if (i_rx_valid) begin
          if (i_rx_data == CMD_OPS) begin
            state_d = ST_GET_A;
          end else if (i_rx_data == CMD_NOOPS) begin
            state_d    = ST_GET_FUN;
            ops_flag_d = 1'b0;
          end
        end
      end
      ST_GET_A: begin
        if (i_rx_valid) begin
          a_d     = i_rx_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (i_rx_valid) begin
          b_d        = i_rx_data;
          ops_flag_d = 1'b1;
          state_d    = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (i_rx_valid) begin
          fun_d   = i_rx_data[FUN-1:0];
          state_d = ops_flag_q ? ST_WR_A : ST_ALU_RUN;
        end
      end
      ST_WR_A: state_d = ST_WR_B;
      ST_WR_B: state_d = ST_ALU_RUN;
      ST_ALU_RUN: begin
        cnt_d   = '0;
        state_d = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: begin
        // A result arriving on the last counted cycle still wins over the timeout
        if (i_alu_valid) begin
          res_d   = i_alu_res;
          state_d = ST_TX_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_TX_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TX_LO:  if (i_tx_ready) state_d = ST_TX_HI;
      ST_TX_HI:  if (i_tx_ready) state_d = ST_IDLE;
      ST_TX_ERR: if (i_tx_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered outputs line up with the state register
  always_comb begin
    rf_wr_en_d = 1'b0;
    rf_addr_d  = '0;
    rf_wdata_d = '0;
    alu_en_d   = 1'b0;
    alu_fun_d  = alu_fun_q;   // function code stays visible until the next run
    tx_valid_d = 1'b0;
    tx_data_d  = '0;

    case (state_d)
      ST_WR_A: begin
        rf_wr_en_d = 1'b1;
        rf_addr_d  = ADDR_W'(OPA_ADDR);
        rf_wdata_d = a_d;
      end
      ST_WR_B: begin
        rf_wr_en_d = 1'b1;
        rf_addr_d  = ADDR_W'(OPB_ADDR);
        rf_wdata_d = b_d;
      end
      ST_ALU_RUN: begin
        alu_en_d  = 1'b1;
        alu_fun_d = fun_d;
      end
      ST_TX_LO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_d[DATA_W-1:0];
      end
      ST_TX_HI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = res_d[BUSR-1:DATA_W];
      end
      ST_TX_ERR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ERR_BYTE;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Bytes arriving while the frame is being executed or returned cannot be parsed
    rx_drop_d = i_rx_valid &&
                ((state_q == ST_WR_A)     || (state_q == ST_WR_B)  ||
                 (state_q == ST_ALU_RUN)  || (state_q == ST_ALU_WAIT) ||
                 (state_q == ST_TX_LO)    || (state_q == ST_TX_HI) ||
                 (state_q == ST_TX_ERR));
  end

  // State, context and output registers; reset aborts any frame in flight
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      ops_flag_q <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      rf_wr_en_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      ops_flag_q <= ops_flag_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign o_rf_wr_en = rf_wr_en_q;
  assign o_rf_addr  = rf_addr_q;
  assign o_rf_wdata = rf_wdata_q;
  assign o_alu_en   = alu_en_q;
  assign o_alu_fun  = alu_fun_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = busy_q;
  assign o_rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames, scoreboard queues for rf writes, ALU runs and TX bytes.
// The ALU and register file are modelled behind the DUT; expected bytes are hand-computed constants.
// TX ready is driven by the stimulus to exercise stalls.
module tb_alu_cmd_ctrl;
  import alu_sys_pkg::*;

  localparam int TIMEOUT = 8;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rf_wr_en;
  logic [3:0]  o_rf_addr;
  logic [7:0]  o_rf_wdata;
  logic        o_alu_en;
  logic [3:0]  o_alu_fun;
  logic [15:0] i_alu_res;
  logic        i_alu_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_rx_drop;

  always #5 i_clk = ~i_clk;

  alu_cmd_ctrl dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rf_wr_en (o_rf_wr_en),
    .o_rf_addr  (o_rf_addr),
    .o_rf_wdata (o_rf_wdata),
    .o_alu_en   (o_alu_en),
    .o_alu_fun  (o_alu_fun),
    .i_alu_res  (i_alu_res),
    .i_alu_valid(i_alu_valid),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_rx_drop  (o_rx_drop)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          drop_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  logic [3:0]  fun_q[$];
  logic [7:0]  rf[0:15];
  bit          alu_alive = 1'b1;
  int          alu_lat = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      FUN_ADD:  return 16'(a) + 16'(b);
      FUN_SUB:  return 16'(a) - 16'(b);
      FUN_MUL:  return 16'(a) * 16'(b);
      FUN_CMPG: return (a > b) ? 16'd2 : 16'd0;
      default:  return 16'd0;
    endcase
  endfunction

  // Register-file and ALU stand-ins: registered ALU answers alu_lat+1 cycles after o_alu_en
  initial begin
    logic [15:0] r;
    i_alu_valid = 1'b0;
    i_alu_res   = '0;
    forever begin
      @(negedge i_clk);
      if (o_alu_en && alu_alive) begin
        r = alu_f(o_alu_fun, rf[0], rf[1]);
        repeat (alu_lat) @(posedge i_clk);
        @(posedge i_clk); #1;
        i_alu_valid = 1'b1;
        i_alu_res   = r;
        @(posedge i_clk); #1;
        i_alu_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, an ALU run or a TX handshake
  initial begin
    int          last_wr_cyc;
    logic [11:0] ew;
    logic [3:0]  ef;
    logic [7:0]  et;
    last_wr_cyc = 0;
    forever begin
      @(negedge i_clk);
      if (i_arst_n) begin
        if (o_rx_drop) drop_cnt++;
        if (o_rf_wr_en) begin
          rf[o_rf_addr] = o_rf_wdata;
          if (wr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rf_write: got addr %0h data %0h, expected no write", o_rf_addr, o_rf_wdata);
          end else begin
            ew = wr_q.pop_front();
            chk("rf_write", {20'd0, o_rf_addr, o_rf_wdata}, {20'd0, ew});
            if (o_rf_addr == 4'd1) chk("rf_write_consecutive", cyc - last_wr_cyc, 1);
          end
          last_wr_cyc = cyc;
        end
        if (o_alu_en) begin
          if (fun_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL alu_en: got pulse fun %0h, expected no pulse", o_alu_fun);
          end else begin
            ef = fun_q.pop_front();
            chk("alu_fun", o_alu_fun, ef);
          end
        end
        if (o_tx_valid && i_tx_ready) begin
          if (tx_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL tx_byte: got %0h, expected no byte", o_tx_data);
          end else begin
            et = tx_q.pop_front();
            chk("tx_byte", o_tx_data, et);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic frame_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    wr_q.push_back({4'h0, a});
    wr_q.push_back({4'h1, b});
    fun_q.push_back(f[3:0]);
    send_byte(DEF_CMD_OPS);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic frame_noops(input logic [7:0] f);
    fun_q.push_back(f[3:0]);
    send_byte(DEF_CMD_NOOPS);
    send_byte(f);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_busy && n < 300);
    chk({name, "_idle"}, o_busy, 0);
    chk({name, "_queues_empty"}, tx_q.size() + wr_q.size() + fun_q.size(), 0);
  endtask

  task automatic wait_sig(input string name, input bit want_alu_en);
    int n = 0;
    while (((want_alu_en && !o_alu_en) || (!want_alu_en && !o_tx_valid)) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_seen"}, n < 100, 1);
  endtask

  function automatic logic [31:0] all_outs();
    return {3'd0, o_rf_wr_en, o_rf_addr, o_rf_wdata, o_alu_en, o_alu_fun,
            o_tx_data, o_tx_valid, o_busy, o_rx_drop};
  endfunction

  initial begin
    int m;
    int base;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    i_arst_n   = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    #3 i_arst_n = 1'b0;
    #1 chk("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge i_clk);
    i_arst_n = 1'b1;

    // Stray byte in IDLE: no state change, no drop pulse
    send_byte(8'h55);
    @(negedge i_clk);
    chk("stray_busy", o_busy, 0);
    chk("stray_drop", o_rx_drop, 0);

    // ADD 07+05 = 0x000C
    tx_q.push_back(8'h0C); tx_q.push_back(8'h00);
    frame_ops(8'h07, 8'h05, 8'h00);
    wait_idle("add");

    // MUL FF*FF = 0xFE01 with three stalled cycles on the low byte
    i_tx_ready = 1'b0;
    tx_q.push_back(8'h01); tx_q.push_back(8'hFE);
    frame_ops(8'hFF, 8'hFF, 8'h02);
    wait_sig("mul_tx", 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge i_clk);
      chk("mul_stall_valid", o_tx_valid, 1);
      chk("mul_stall_data", o_tx_data, 8'h01);
    end
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    wait_idle("mul");

    // Store A=09, B=04 (ADD -> 0x000D), then CMPG on stored operands -> 0x0002
    tx_q.push_back(8'h0D); tx_q.push_back(8'h00);
    frame_ops(8'h09, 8'h04, 8'h00);
    wait_idle("store");
    tx_q.push_back(8'h02); tx_q.push_back(8'h00);
    frame_noops(8'h0B);
    wait_idle("cmpg");

    // Unused code F with junk upper bits: runs anyway, ALU returns 0
    tx_q.push_back(8'h00); tx_q.push_back(8'h00);
    frame_noops(8'h5F);
    wait_idle("unused_fun");

    // ALU silent: ALU_WAIT spans TIMEOUT cycles, then EE appears the following cycle
    alu_alive = 1'b0;
    tx_q.push_back(DEF_ERR_BYTE);
    frame_ops(8'h01, 8'h02, 8'h00);
    wait_sig("timeout_alu_en", 1'b1);
    m = 0;
    do begin
      @(negedge i_clk);
      m++;
    end while (!o_tx_valid && m < 50);
    chk("timeout_latency", m, TIMEOUT + 1);
    chk("timeout_err_byte", o_tx_data, DEF_ERR_BYTE);
    wait_idle("timeout");
    alu_alive = 1'b1;

    // Byte injected during ALU_WAIT: one drop pulse, stored 01+02 = 0x0003 returned
    alu_lat = 3;
    base = drop_cnt;
    tx_q.push_back(8'h03); tx_q.push_back(8'h00);
    frame_noops(8'h00);
    wait_sig("drop_alu_en", 1'b1);
    send_byte(8'h77);
    wait_idle("drop");
    chk("drop_count", drop_cnt - base, 1);
    alu_lat = 0;

    // Reset in TX_HI: 80+80 = 0x0100, low byte accepted, reset before high byte
    i_tx_ready = 1'b0;
    tx_q.push_back(8'h00);
    frame_ops(8'h80, 8'h80, 8'h00);
    wait_sig("rst_tx", 1'b0);
    @(posedge i_clk); #1;
    i_tx_ready = 1'b1;
    @(posedge i_clk); #1;
    i_tx_ready = 1'b0;
    @(negedge i_clk);
    chk("rst_tx_hi_data", {o_tx_valid, o_tx_data}, {1'b1, 8'h01});
    #2 i_arst_n = 1'b0;
    #1 chk("midframe_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge i_clk);
    i_arst_n   = 1'b1;
    i_tx_ready = 1'b1;

    // SUB 03-02 = 0x0001 after reset
    tx_q.push_back(8'h01); tx_q.push_back(8'h00);
    frame_ops(8'h03, 8'h02, 8'h01);
    wait_idle("sub");
    chk("total_drops", drop_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
